// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a DEPTH-entry prefetch FIFO.
// Fetches sequentially from instruction memory, tags each word with its PC,
// and hands {pc, inst} pairs to the RR stage. A redirect flushes everything
// and restarts fetch at a new PC.
//
// Handshake semantics:
//   imem side : a word is accepted on a rising edge where imem_req and imem_ack
//               are both 1. imem_req depends only on reset, redirect and
//               occupancy (never on out_ready), so the memory may see a request
//               withdrawn (full or redirect) and must ignore it. While
//               imem_ack=0 the address is held stable for any number of cycles.
//   out side  : the head entry transfers on a rising edge where out_valid and
//               out_ready are both 1 and no redirect is present. out_valid
//               never depends on out_ready.
//   redirect  : overrides both handshakes on the edge where it is sampled.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_STEP  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h00000013)
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_ack,
  input  logic [XLEN-1:0]            imem_data,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_inst,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]  fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [XLEN-1:0]  inst_mem [DEPTH];

  logic full;
  logic push;
  logic pop;

  // The request is suppressed when full even if a pop frees a slot this
  // cycle; this keeps imem_req independent of out_ready.
  assign full      = (count == CNT_W'(DEPTH));
  assign imem_req  = reset & ~redirect & ~full;
  assign imem_addr = fetch_pc;

  // imem_req already excludes redirect, so an ack during a redirect is dropped.
  assign push      = imem_req & imem_ack;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~redirect;

  // Head presentation: NOP and PC 0 whenever the queue is empty.
  always_comb begin
    out_inst = NOP_INST;
    out_pc   = '0;
    if (out_valid) begin
      out_inst = inst_mem[rd_ptr];
      out_pc   = pc_mem[rd_ptr];
    end
  end

  // Control state: fetch PC, pointers and occupancy, redirect has priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue with a scoreboard.
// Stimulus pushes the expected {pc, inst} of every entry it intends to be
// consumed; a monitor pops and compares on each head transfer.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] NOP = 32'h00000013;

  logic             clock;
  logic             reset;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             imem_ack;
  logic [XLEN-1:0]  imem_data;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_inst;
  logic [XLEN-1:0]  out_pc;
  logic [CNT_W-1:0] count;

  logic [2*XLEN-1:0] exp_q[$];
  int n_checks;
  int n_pass;

  fetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(32'h0), .NOP_INST(NOP)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc),
    .count(count)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: instruction word is a fixed function of its address.
  function automatic logic [XLEN-1:0] inst_of(input logic [XLEN-1:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  assign imem_data = inst_of(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_pc(input logic [XLEN-1:0] pc);
    exp_q.push_back({pc, inst_of(pc)});
  endtask

  // Monitor: inputs are stable at the falling edge, so a transfer seen here
  // is the one the next rising edge performs.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected_pc", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [2*XLEN-1:0] e;
        e = exp_q.pop_front();
        check("pop_pc",   64'(out_pc),   64'(e[2*XLEN-1:XLEN]));
        check("pop_inst", 64'(out_inst), 64'(e[XLEN-1:0]));
      end
    end
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b0;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_count",     64'(count),     64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_inst",  64'(out_inst),  64'(NOP));
    check("rst_out_pc",    64'(out_pc),    64'd0);
    check("rst_imem_req",  64'(imem_req),  64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);

    // Fill with consumer stalled: count 1..4 then request drops
    reset = 1'b1; imem_ack = 1'b1; out_ready = 1'b0;
    #1;
    check("fill_req_start", 64'(imem_req), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("fill_count", 64'(count), 64'(k));
      check("fill_head_pc", 64'(out_pc), 64'd0);
    end
    check("fill_full_req", 64'(imem_req), 64'd0);
    check("fill_addr", 64'(imem_addr), 64'd4);

    // Drain: entries must be PCs 0..3
    for (int p = 0; p < 4; p++) expect_pc(XLEN'(p));
    imem_ack = 1'b0; out_ready = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      tick();
      check("drain_count", 64'(count), 64'(k));
    end

    // Wait states at fetch_pc=5
    expect_pc(32'd4); expect_pc(32'd5);
    imem_ack = 1'b1;
    tick();
    check("ws_push4_addr", 64'(imem_addr), 64'd5);
    imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ws_hold_addr", 64'(imem_addr), 64'd5);
      check("ws_hold_req",  64'(imem_req),  64'd1);
    end
    imem_ack = 1'b1;
    tick();
    check("ws_after_addr", 64'(imem_addr), 64'd6);
    check("ws_after_count", 64'(count), 64'd1);
    imem_ack = 1'b0;
    tick();
    check("ws_drain_count", 64'(count), 64'd0);

    // Streaming: one per cycle, count stays at 1
    for (int p = 6; p <= 11; p++) expect_pc(XLEN'(p));
    imem_ack = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("stream_count", 64'(count), 64'd1);
      check("stream_head",  64'(out_pc), 64'(5 + k));
    end
    imem_ack = 1'b0;
    tick();
    check("stream_end_count", 64'(count), 64'd0);
    check("stream_end_addr",  64'(imem_addr), 64'd12);

    // Redirect with three entries queued
    imem_ack = 1'b1; out_ready = 1'b0;
    tick(); tick(); tick();
    check("redir_pre_count", 64'(count), 64'd3);
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    check("redir_req_low", 64'(imem_req), 64'd0);
    tick();
    redirect = 1'b0;
    check("redir_count",     64'(count),     64'd0);
    check("redir_out_valid", 64'(out_valid), 64'd0);
    check("redir_addr",      64'(imem_addr), 64'h40);
    expect_pc(32'h40);
    tick();
    check("redir_head_pc", 64'(out_pc), 64'h40);
    imem_ack = 1'b0; out_ready = 1'b1;
    tick();
    check("redir_drain_count", 64'(count), 64'd0);

    // Redirect together with ack and ready, then a back-to-back redirect
    imem_ack = 1'b1; out_ready = 1'b0;
    tick();
    check("sim_pre_count", 64'(count), 64'd1);
    redirect = 1'b1; redirect_pc = 32'h80; out_ready = 1'b1;
    tick();
    check("sim_count", 64'(count), 64'd0);
    check("sim_out_valid", 64'(out_valid), 64'd0);
    redirect_pc = 32'h90;
    tick();
    redirect = 1'b0;
    check("b2b_addr",  64'(imem_addr), 64'h90);
    check("b2b_count", 64'(count), 64'd0);
    expect_pc(32'h90); expect_pc(32'h91);
    tick(); tick();
    imem_ack = 1'b0;
    tick();
    check("b2b_drain_count", 64'(count), 64'd0);

    // Asynchronous reset while streaming
    expect_pc(32'h92); expect_pc(32'h93);
    imem_ack = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    check("ar_pre_count", 64'(count), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_count",     64'(count),     64'd0);
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_out_inst",  64'(out_inst),  64'(NOP));
    check("ar_imem_req",  64'(imem_req),  64'd0);
    check("ar_imem_addr", 64'(imem_addr), 64'd0);
    imem_ack = 1'b0; out_ready = 1'b0;
    tick(); tick();

    check("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end. It replaces the single PC register and stall-gated PC clock of the 5-stage core with a prefetch FIFO of DEPTH entries.
- Fetches sequentially from instruction memory over a req/ack handshake, tagging each instruction with its PC.
- Presents instructions to the RR stage over a valid/ready interface.
- Accepts a redirect (branch/jump) that flushes the queue.

Parameters:
- XLEN, 32, width of PC and instruction word.
- DEPTH, 4, queue entries; power of two, at least 2.
- PC_STEP, 1, PC increment per instruction (word addressing, as in the core).
- RESET_PC, 0, fetch PC after reset.
- NOP_INST, 32'h00000013, value driven on out_inst when out_valid=0.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (current fetch PC).
- imem_ack  in  1  memory has the data for imem_addr; meaningful only while imem_req=1.
- imem_data  in  XLEN  instruction word, valid when imem_req and imem_ack are both 1.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_inst  out  XLEN  head instruction, or NOP_INST when empty.
- out_pc  out  XLEN  PC of the head instruction, 0 when empty.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- State:
  - fetch_pc, XLEN bits.
  - Storage of DEPTH x {pc, inst}.
  - rd_ptr and wr_ptr, log2(DEPTH) bits each, wrapping mod DEPTH.
  - count register.
- Reset (reset=0, async, effective immediately):
  - fetch_pc=RESET_PC; rd_ptr=wr_ptr=0; count=0.
  - Outputs: out_valid=0, out_inst=NOP_INST, out_pc=0, imem_req=0, imem_addr=RESET_PC.
  - Storage contents need not be cleared.
- imem_addr = fetch_pc at all times.
- imem_req = reset & ~redirect & (count < DEPTH). Combinational, with no dependence on out_ready. The request is not issued when full, even if a pop occurs that cycle.
- Push: imem_req & imem_ack & ~redirect at a clock edge. The edge writes {fetch_pc, imem_data} at wr_ptr, then advances wr_ptr, and sets fetch_pc += PC_STEP (mod 2^XLEN).
- Wait states: while imem_req=1 and imem_ack=0, fetch_pc and imem_addr hold. Any number of wait cycles is allowed. The memory must ignore a withdrawn request.
- Head outputs: out_valid = (count != 0). out_inst and out_pc come from the entry at rd_ptr. Output latency is 1 cycle: ack at edge N gives out_valid at edge N+1 when the queue was empty.
- Pop: out_valid & out_ready & ~redirect at a clock edge advances rd_ptr.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: unchanged.
  - Neither overflows: push is impossible at DEPTH, and pop is impossible at 0.
- Redirect (redirect=1 at an edge), highest priority:
  - rd_ptr=wr_ptr=0, count=0, fetch_pc=redirect_pc.
  - A simultaneous imem_ack is discarded, because imem_req=0 in that cycle.
  - A simultaneous out_ready pop has no additional effect.
  - Next cycle: out_valid=0 and imem_addr=redirect_pc.
- Back-to-back redirects: the last one wins; fetch resumes at the last redirect_pc.
- Throughput: one instruction per cycle with a zero-wait memory and out_ready=1.

Test Plan:
- Reset released, imem_ack=1 always, out_ready=0, DEPTH=4:
  - count goes 1,2,3,4 on successive edges, then imem_req=0.
  - Head out_pc=0, and the entries hold PCs 0,1,2,3.
- imem_ack=1 and out_ready=1 continuous:
  - out_valid=1 from the second edge after reset.
  - out_pc follows 0,1,2,3,... with one per cycle, and count stays at 1.
- imem_ack held low for 3 cycles at fetch_pc=5, then high:
  - imem_addr stays 5 throughout, with exactly one push of PC 5.
  - Next imem_addr=6.
- count=3 and redirect=1 with redirect_pc=0x40:
  - Next cycle count=0, out_valid=0, imem_addr=0x40.
  - The first subsequent head entry has out_pc=0x40.
- redirect, imem_ack and out_ready all asserted in the same cycle:
  - Nothing is pushed and count=0.
  - No stale instruction appears later; the next out_pc equals redirect_pc.
- reset driven low between edges while streaming:
  - Immediately (no clock): count=0, out_valid=0, out_inst=NOP_INST, imem_req=0, imem_addr=RESET_PC.
